// File: rtl/clocks_multi_if.sv
// Control/status bundle for clocks_multi: run control, per-channel timing
// parameters and the generated clock/active outputs.
interface clocks_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CW     = 32
);
  logic                 enable_i;
  logic                 resync_i;
  logic [NUM_CH*CW-1:0] PERIOD;
  logic [NUM_CH-1:0]    PERIOD_WSTB;
  logic [NUM_CH*CW-1:0] WIDTH;
  logic [NUM_CH*CW-1:0] DELAY;
  logic [NUM_CH-1:0]    clock_o;
  logic [NUM_CH-1:0]    active_o;

  modport master (
    output enable_i, resync_i, PERIOD, PERIOD_WSTB, WIDTH, DELAY,
    input  clock_o, active_o
  );

  modport slave (
    input  enable_i, resync_i, PERIOD, PERIOD_WSTB, WIDTH, DELAY,
    output clock_o, active_o
  );
endinterface

// File: rtl/clocks_multi.sv
// NUM_CH independent periodic clock generators with programmable period, high
// time and start delay; period/width are shadowed so live outputs never glitch.
module clocks_multi #(
  parameter int NUM_CH = 4,
  parameter int CW     = 32
) (
  input  logic           clk_i,
  input  logic           reset_i,
  clocks_multi_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_TWO  = {{(CW-2){1'b0}}, 2'b10};

  state_t            state_r [NUM_CH];
  logic [CW-1:0]     cnt_r   [NUM_CH];
  logic [CW-1:0]     dcnt_r  [NUM_CH];
  logic [CW-1:0]     dly_r   [NUM_CH];
  logic [CW-1:0]     p_sh_r  [NUM_CH];
  logic [CW-1:0]     w_sh_r  [NUM_CH];
  logic [NUM_CH-1:0] clock_r;
  logic [NUM_CH-1:0] active_r;
  logic              en_prev_r;
  logic [NUM_CH-1:0] start_s;

  // High time actually used: the programmed width if it fits, else half period.
  function automatic logic [CW-1:0] eff_width(input logic [CW-1:0] p,
                                              input logic [CW-1:0] w);
    if ((w != CNT_ZERO) && (w < p)) begin
      return w;
    end else begin
      return p >> 1;
    end
  endfunction

  // Start events per channel; simultaneous sources merge into one restart.
  always_comb begin
    start_s = {NUM_CH{1'b0}};
    for (int n = 0; n < NUM_CH; n++) begin
      start_s[n] = bus.enable_i & (~en_prev_r | bus.resync_i | bus.PERIOD_WSTB[n]);
    end
  end

  // Per-channel IDLE/WAIT/RUN state machines with registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      // Treat enable as already seen high so leaving reset never self-starts.
      en_prev_r <= 1'b1;
      clock_r   <= {NUM_CH{1'b0}};
      active_r  <= {NUM_CH{1'b0}};
      for (int n = 0; n < NUM_CH; n++) begin
        state_r[n] <= ST_IDLE;
        cnt_r[n]   <= CNT_ZERO;
        dcnt_r[n]  <= CNT_ZERO;
        dly_r[n]   <= CNT_ZERO;
        p_sh_r[n]  <= CNT_ZERO;
        w_sh_r[n]  <= CNT_ZERO;
      end
    end else begin
      en_prev_r <= bus.enable_i;
      for (int n = 0; n < NUM_CH; n++) begin
        if (!bus.enable_i) begin
          state_r[n]  <= ST_IDLE;
          cnt_r[n]    <= CNT_ZERO;
          dcnt_r[n]   <= CNT_ZERO;
          clock_r[n]  <= 1'b0;
          active_r[n] <= 1'b0;
        end else if (start_s[n]) begin
          p_sh_r[n]  <= bus.PERIOD[n*CW +: CW];
          w_sh_r[n]  <= bus.WIDTH[n*CW +: CW];
          dly_r[n]   <= bus.DELAY[n*CW +: CW];
          dcnt_r[n]  <= CNT_ZERO;
          cnt_r[n]   <= CNT_ZERO;
          clock_r[n] <= 1'b0;
          if (bus.DELAY[n*CW +: CW] == CNT_ZERO) begin
            state_r[n]  <= ST_RUN;
            active_r[n] <= 1'b1;
          end else begin
            state_r[n]  <= ST_WAIT;
            active_r[n] <= 1'b0;
          end
        end else begin
          case (state_r[n])
            ST_WAIT: begin
              clock_r[n] <= 1'b0;
              // dly_r is non-zero here, so the subtraction cannot wrap.
              if (dcnt_r[n] == (dly_r[n] - CNT_ONE)) begin
                state_r[n]  <= ST_RUN;
                active_r[n] <= 1'b1;
                cnt_r[n]    <= CNT_ZERO;
              end else begin
                dcnt_r[n]   <= dcnt_r[n] + CNT_ONE;
              end
            end
            ST_RUN: begin
              active_r[n] <= 1'b1;
              if (p_sh_r[n] < CNT_TWO) begin
                clock_r[n] <= 1'b0;
                cnt_r[n]   <= CNT_ZERO;
                p_sh_r[n]  <= bus.PERIOD[n*CW +: CW];
                w_sh_r[n]  <= bus.WIDTH[n*CW +: CW];
              end else begin
                clock_r[n] <= (cnt_r[n] < eff_width(p_sh_r[n], w_sh_r[n]));
                if (cnt_r[n] == (p_sh_r[n] - CNT_ONE)) begin
                  cnt_r[n]  <= CNT_ZERO;
                  p_sh_r[n] <= bus.PERIOD[n*CW +: CW];
                  w_sh_r[n] <= bus.WIDTH[n*CW +: CW];
                end else begin
                  cnt_r[n]  <= cnt_r[n] + CNT_ONE;
                end
              end
            end
            default: begin
              state_r[n]  <= ST_IDLE;
              clock_r[n]  <= 1'b0;
              active_r[n] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.clock_o  = clock_r;
  assign bus.active_o = active_r;

endmodule

// File: tb/tb_clocks_multi.sv
// Scoreboard bench for clocks_multi: expected {active,clock} per channel per
// cycle is queued when stimulus starts and popped after every clock edge.
module tb_clocks_multi;
  localparam int NCH = 4;
  localparam int CWD = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [1:0] exq [NCH][$];

  clocks_multi_if #(.NUM_CH(NCH), .CW(CWD)) bus ();
  clocks_multi #(.NUM_CH(NCH), .CW(CWD)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned weff(int unsigned p, int unsigned w);
    if (w != 0 && w < p) return w;
    return p / 2;
  endfunction

  task automatic set_ch(int ch, int unsigned p, int unsigned w, int unsigned d);
    bus.PERIOD[ch*CWD +: CWD] = p;
    bus.WIDTH[ch*CWD +: CWD]  = w;
    bus.DELAY[ch*CWD +: CWD]  = d;
  endtask

  // Edge T0 plus the d delay edges: clock low, active from the edge RUN is entered.
  task automatic push_start(int ch, int d);
    exq[ch].push_back({(d == 0) ? 1'b1 : 1'b0, 1'b0});
    for (int t = 1; t <= d; t++) exq[ch].push_back({(t == d) ? 1'b1 : 1'b0, 1'b0});
  endtask

  task automatic push_run(int ch, int unsigned p, int unsigned w, int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = 1'b0;
      if (p >= 2) b = ((i % p) < weff(p, w));
      exq[ch].push_back({1'b1, b});
    end
  endtask

  task automatic push_idle(int ch, int n);
    for (int i = 0; i < n; i++) exq[ch].push_back(2'b00);
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if (bus.clock_o !== 4'b0000) begin errors++; $display("FAIL reset_clock: got %b expected 0000", bus.clock_o); end
    checks++;
    if (bus.active_o !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b expected 0000", bus.active_o); end
    #2 rst = 1'b0;
    step(); step();
    checks++;
    if (bus.clock_o !== 4'b0000) begin errors++; $display("FAIL idle_clock: got %b expected 0000", bus.clock_o); end
    checks++;
    if (bus.active_o !== 4'b0000) begin errors++; $display("FAIL idle_active: got %b expected 0000", bus.active_o); end
  endtask

  task automatic test_basic();
    int n;
    logic [1:0] e;
    logic [1:0] g;
    int unsigned per [NCH] = '{10, 7, 5, 0};
    for (int c = 0; c < NCH; c++) begin
      set_ch(c, per[c], 0, 0);
      push_start(c, 0); push_run(c, per[c], 0, 40); push_idle(c, 2);
    end
    n = exq[0].size();
    for (int k = 0; k < n; k++) begin
      if (k == 0)  bus.enable_i = 1'b1;
      if (k == 41) bus.enable_i = 1'b0;
      step();
      for (int c = 0; c < NCH; c++) begin
        e = exq[c].pop_front();
        g = {bus.active_o[c], bus.clock_o[c]};
        checks++;
        if (g !== e) begin errors++; $display("FAIL basic ch%0d k%0d: got act,clk=%b expected %b", c, k, g, e); end
      end
    end
  endtask

  task automatic test_width();
    int n;
    logic [1:0] e;
    logic [1:0] g;
    set_ch(0, 5, 2, 0);
    push_start(0, 0); push_run(0, 5, 2, 15); push_run(0, 5, 4, 10); push_idle(0, 2);
    for (int c = 1; c < NCH; c++) begin
      set_ch(c, 0, 0, 0);
      push_start(c, 0); push_run(c, 0, 0, 25); push_idle(c, 2);
    end
    n = exq[0].size();
    for (int k = 0; k < n; k++) begin
      if (k == 0)  bus.enable_i = 1'b1;
      if (k == 3)  bus.WIDTH[0 +: CWD] = 9;
      if (k == 12) bus.WIDTH[0 +: CWD] = 4;
      if (k == 26) bus.enable_i = 1'b0;
      step();
      for (int c = 0; c < NCH; c++) begin
        e = exq[c].pop_front();
        g = {bus.active_o[c], bus.clock_o[c]};
        checks++;
        if (g !== e) begin errors++; $display("FAIL width ch%0d k%0d: got act,clk=%b expected %b", c, k, g, e); end
      end
    end
  endtask

  task automatic test_delay();
    int n;
    logic [1:0] e;
    logic [1:0] g;
    for (int c = 0; c < NCH; c++) begin
      set_ch(c, 12, 0, 3 * c);
      push_start(c, 3 * c); push_run(c, 12, 0, 40 - 3 * c); push_idle(c, 2);
    end
    n = exq[0].size();
    for (int k = 0; k < n; k++) begin
      if (k == 0)  bus.enable_i = 1'b1;
      if (k == 41) bus.enable_i = 1'b0;
      step();
      for (int c = 0; c < NCH; c++) begin
        e = exq[c].pop_front();
        g = {bus.active_o[c], bus.clock_o[c]};
        checks++;
        if (g !== e) begin errors++; $display("FAIL delay ch%0d k%0d: got act,clk=%b expected %b", c, k, g, e); end
      end
    end
  endtask

  task automatic test_period_update();
    int n;
    logic [1:0] e;
    logic [1:0] g;
    set_ch(0, 10, 0, 0);
    push_start(0, 0); push_run(0, 10, 0, 10); push_run(0, 4, 0, 9);
    push_start(0, 0); push_run(0, 10, 0, 10); push_idle(0, 2);
    for (int c = 1; c < NCH; c++) begin
      set_ch(c, 0, 0, 0);
      push_start(c, 0); push_run(c, 0, 0, 30); push_idle(c, 2);
    end
    n = exq[0].size();
    for (int k = 0; k < n; k++) begin
      if (k == 0) bus.enable_i = 1'b1;
      if (k == 4) bus.PERIOD[0 +: CWD] = 4;
      if (k == 20) begin bus.PERIOD[0 +: CWD] = 10; bus.PERIOD_WSTB = 4'b0001; end
      if (k == 21) bus.PERIOD_WSTB = 4'b0000;
      if (k == 31) bus.enable_i = 1'b0;
      step();
      for (int c = 0; c < NCH; c++) begin
        e = exq[c].pop_front();
        g = {bus.active_o[c], bus.clock_o[c]};
        checks++;
        if (g !== e) begin errors++; $display("FAIL period ch%0d k%0d: got act,clk=%b expected %b", c, k, g, e); end
      end
    end
  endtask

  task automatic test_resync();
    int n;
    logic [1:0] e;
    logic [1:0] g;
    int unsigned per [NCH] = '{6, 5, 8, 3};
    for (int c = 0; c < NCH; c++) begin
      set_ch(c, per[c], 0, c);
      push_start(c, c); push_run(c, per[c], 0, 11 - c);
      push_start(c, c); push_run(c, per[c], 0, 18 - c); push_idle(c, 2);
    end
    n = exq[0].size();
    for (int k = 0; k < n; k++) begin
      if (k == 0)  bus.enable_i = 1'b1;
      if (k == 12) begin bus.resync_i = 1'b1; bus.PERIOD_WSTB = 4'b0010; end
      if (k == 13) begin bus.resync_i = 1'b0; bus.PERIOD_WSTB = 4'b0000; end
      if (k == 31) bus.enable_i = 1'b0;
      step();
      for (int c = 0; c < NCH; c++) begin
        e = exq[c].pop_front();
        g = {bus.active_o[c], bus.clock_o[c]};
        checks++;
        if (g !== e) begin errors++; $display("FAIL resync ch%0d k%0d: got act,clk=%b expected %b", c, k, g, e); end
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    logic [1:0] e;
    logic [1:0] g;
    set_ch(0, 10, 0, 0);
    push_start(0, 0); push_run(0, 10, 0, 3);
    for (int c = 1; c < NCH; c++) begin
      set_ch(c, 0, 0, 0);
      push_start(c, 0); push_run(c, 0, 0, 3);
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 0) bus.enable_i = 1'b1;
      step();
      for (int c = 0; c < NCH; c++) begin
        e = exq[c].pop_front();
        g = {bus.active_o[c], bus.clock_o[c]};
        checks++;
        if (g !== e) begin errors++; $display("FAIL arst_pre ch%0d k%0d: got act,clk=%b expected %b", c, k, g, e); end
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.clock_o !== 4'b0000) begin errors++; $display("FAIL arst_clock: got %b expected 0000", bus.clock_o); end
    checks++;
    if (bus.active_o !== 4'b0000) begin errors++; $display("FAIL arst_active: got %b expected 0000", bus.active_o); end
    #2 rst = 1'b0;
    push_idle(0, 5); push_start(0, 0); push_run(0, 10, 0, 5); push_idle(0, 2);
    for (int c = 1; c < NCH; c++) begin
      push_idle(c, 5); push_start(c, 0); push_run(c, 0, 0, 5); push_idle(c, 2);
    end
    n = exq[0].size();
    for (int k = 0; k < n; k++) begin
      if (k == 5)  bus.resync_i = 1'b1;
      if (k == 6)  bus.resync_i = 1'b0;
      if (k == 11) bus.enable_i = 1'b0;
      step();
      for (int c = 0; c < NCH; c++) begin
        e = exq[c].pop_front();
        g = {bus.active_o[c], bus.clock_o[c]};
        checks++;
        if (g !== e) begin errors++; $display("FAIL arst_post ch%0d k%0d: got act,clk=%b expected %b", c, k, g, e); end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.enable_i    = 1'b0;
    bus.resync_i    = 1'b0;
    bus.PERIOD_WSTB = 4'b0000;
    bus.PERIOD      = '0;
    bus.WIDTH       = '0;
    bus.DELAY       = '0;
    test_reset();
    test_basic();
    test_width();
    test_delay();
    test_period_update();
    test_resync();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
